// File: rtl/control_sequencer_if.sv
// Control-unit boundary between the hardwired sequencer and the bus datapath.
// The sequencer side (master) consumes IR/Mem_ready/Stop and drives every
// per-cycle strobe; the datapath side (slave) is the mirror image.
//
// Handshake: Mem_ready is a ready-only qualifier on the memory read. The
// sequencer holds Read and MDRin high (T1, then T1W) for as long as
// Mem_ready is low, and the read completes in the first cycle where
// Read=1 and Mem_ready=1; there is no separate valid and no timeout.
interface control_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      IR;
    logic             Mem_ready;
    logic             Stop;

    logic             PCout;
    logic             Zlowout;
    logic             MDRout;
    logic             MARin;
    logic             Zin;
    logic             PCin;
    logic             MDRin;
    logic             IRin;
    logic             Yin;
    logic             IncPC;
    logic             Read;
    logic             ADD;
    logic             SUB;
    logic             AND;
    logic             OR;
    logic             Gra;
    logic             Grb;
    logic             Grc;
    logic             Rin;
    logic             Rout;
    logic             Run;
    logic [CNT_W-1:0] Instr_count;
    logic [3:0]       dbg_state;

    modport master (
        input  IR, Mem_ready, Stop,
        output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, ADD, SUB, AND, OR, Gra, Grb, Grc, Rin, Rout,
               Run, Instr_count, dbg_state
    );

    modport slave (
        output IR, Mem_ready, Stop,
        input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, ADD, SUB, AND, OR, Gra, Grb, Grc, Rin, Rout,
               Run, Instr_count, dbg_state
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the bus-based RISC datapath.
// Fetch T0-T2 (with memory-wait state T1W), decode in T3, and execute
// T4-T5 for three-register ALU instructions. A sticky stop request halts
// the machine at the next instruction boundary. Strobes are a pure
// combinational decode of the current state (plus the opcode in T3/T4).
module control_sequencer #(
    parameter int             OPW     = 5,
    parameter logic [OPW-1:0] HALT_OP = 5'b11111,
    parameter int             CNT_W   = 16
) (
    input logic                 Clock,
    input logic                 Reset,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);

    state_t           state_q, state_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [OPW-1:0]   op;
    logic             is_alu;
    logic             halt_at_boundary;
    logic             unused_ir;

    logic pcout_c, zlowout_c, mdrout_c, marin_c, zin_c, pcin_c, mdrin_c;
    logic irin_c, yin_c, incpc_c, read_c, add_c, sub_c, and_c, or_c;
    logic gra_c, grb_c, grc_c, rin_c, rout_c, run_c;

    // Only the opcode field matters; the register fields are consumed by
    // the datapath's select-and-encode logic, not here.
    assign op        = bus.IR[31 -: OPW];
    assign unused_ir = ^bus.IR[31-OPW:0];
    assign is_alu    = (op == OP_ADD) || (op == OP_SUB) ||
                       (op == OP_AND) || (op == OP_OR);

    // A Stop arriving in the very cycle of the boundary still counts.
    assign halt_at_boundary = stop_q | bus.Stop;

    // State, sticky stop flag and retired-instruction counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_RST;
            stop_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            count_q <= count_d;
        end
    end

    // Next-state, counter update and per-state strobe decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        stop_d    = stop_q |
                    (bus.Stop & (state_q != S_RST) & (state_q != S_HALT));
        pcout_c   = 1'b0;
        zlowout_c = 1'b0;
        mdrout_c  = 1'b0;
        marin_c   = 1'b0;
        zin_c     = 1'b0;
        pcin_c    = 1'b0;
        mdrin_c   = 1'b0;
        irin_c    = 1'b0;
        yin_c     = 1'b0;
        incpc_c   = 1'b0;
        read_c    = 1'b0;
        add_c     = 1'b0;
        sub_c     = 1'b0;
        and_c     = 1'b0;
        or_c      = 1'b0;
        gra_c     = 1'b0;
        grb_c     = 1'b0;
        grc_c     = 1'b0;
        rin_c     = 1'b0;
        rout_c    = 1'b0;
        run_c     = 1'b1;

        case (state_q)
            S_RST: begin
                run_c   = 1'b0;
                state_d = S_T0;
            end
            S_T0: begin
                pcout_c = 1'b1;
                marin_c = 1'b1;
                incpc_c = 1'b1;
                zin_c   = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                zlowout_c = 1'b1;
                pcin_c    = 1'b1;
                read_c    = 1'b1;
                mdrin_c   = 1'b1;
                state_d   = bus.Mem_ready ? S_T2 : S_T1W;
            end
            S_T1W: begin
                // PC was already reloaded in T1; only keep the read open.
                read_c  = 1'b1;
                mdrin_c = 1'b1;
                state_d = bus.Mem_ready ? S_T2 : S_T1W;
            end
            S_T2: begin
                mdrout_c = 1'b1;
                irin_c   = 1'b1;
                state_d  = S_T3;
            end
            S_T3: begin
                if (is_alu) begin
                    grb_c   = 1'b1;
                    rout_c  = 1'b1;
                    yin_c   = 1'b1;
                    state_d = S_T4;
                end else if (op == HALT_OP) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = S_HALT;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    state_d = halt_at_boundary ? S_HALT : S_T0;
                end
            end
            S_T4: begin
                grc_c  = 1'b1;
                rout_c = 1'b1;
                zin_c  = 1'b1;
                case (op)
                    OP_ADD:  add_c = 1'b1;
                    OP_SUB:  sub_c = 1'b1;
                    OP_AND:  and_c = 1'b1;
                    OP_OR:   or_c  = 1'b1;
                    default: ;
                endcase
                state_d = S_T5;
            end
            S_T5: begin
                zlowout_c = 1'b1;
                gra_c     = 1'b1;
                rin_c     = 1'b1;
                count_d   = count_q + CNT_W'(1);
                state_d   = halt_at_boundary ? S_HALT : S_T0;
            end
            S_HALT: begin
                run_c = 1'b0;
            end
            default: begin
                run_c   = 1'b0;
                state_d = S_RST;
            end
        endcase
    end

    assign bus.PCout       = pcout_c;
    assign bus.Zlowout     = zlowout_c;
    assign bus.MDRout      = mdrout_c;
    assign bus.MARin       = marin_c;
    assign bus.Zin         = zin_c;
    assign bus.PCin        = pcin_c;
    assign bus.MDRin       = mdrin_c;
    assign bus.IRin        = irin_c;
    assign bus.Yin         = yin_c;
    assign bus.IncPC       = incpc_c;
    assign bus.Read        = read_c;
    assign bus.ADD         = add_c;
    assign bus.SUB         = sub_c;
    assign bus.AND         = and_c;
    assign bus.OR          = or_c;
    assign bus.Gra         = gra_c;
    assign bus.Grb         = grb_c;
    assign bus.Grc         = grc_c;
    assign bus.Rin         = rin_c;
    assign bus.Rout        = rout_c;
    assign bus.Run         = run_c;
    assign bus.Instr_count = count_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. Each instruction is expanded into its
// list of phases (T0, T1, waits, T2, T3 and optionally T4/T5), and the
// expected strobe/count vector for every cycle is pushed into a queue;
// a monitor on the falling edge pops and compares one vector per cycle.
module tb_control_sequencer;

    localparam int CNT_W = 6;
    localparam int SW    = 21;
    localparam int EW    = SW + CNT_W;

    localparam int P_RST  = 0;
    localparam int P_T0   = 1;
    localparam int P_T1   = 2;
    localparam int P_T1W  = 3;
    localparam int P_T2   = 4;
    localparam int P_T3   = 5;
    localparam int P_T4   = 6;
    localparam int P_T5   = 7;
    localparam int P_HALT = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if #(.CNT_W(CNT_W)) bus ();

    control_sequencer #(
        .OPW     (5),
        .HALT_OP (5'b11111),
        .CNT_W   (CNT_W)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // ---------------- reference model state ----------------
    logic [EW-1:0]    exp_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] m_count;
    bit               m_stop;
    bit               m_halted;

    // Strobes the machine should show in a given phase, straight from the
    // phase table. Order: PCout Zlowout MDRout MARin Zin PCin MDRin IRin Yin
    // IncPC Read ADD SUB AND OR Gra Grb Grc Rin Rout Run.
    function automatic logic [SW-1:0] strobes_for(int ph, logic [4:0] op);
        logic pcout, zlowout, mdrout, marin, zin, pcin, mdrin, irin, yin;
        logic incpc, read, s_add, s_sub, s_and, s_or, gra, grb, grc, rin, rout, run;
        bit alu;
        {pcout, zlowout, mdrout, marin, zin, pcin, mdrin, irin, yin} = '0;
        {incpc, read, s_add, s_sub, s_and, s_or, gra, grb, grc, rin, rout} = '0;
        alu = (op <= 5'd3);
        run = (ph != P_RST) && (ph != P_HALT);
        case (ph)
            P_T0:  begin pcout = 1; marin = 1; incpc = 1; zin = 1; end
            P_T1:  begin zlowout = 1; pcin = 1; read = 1; mdrin = 1; end
            P_T1W: begin read = 1; mdrin = 1; end
            P_T2:  begin mdrout = 1; irin = 1; end
            P_T3:  if (alu) begin grb = 1; rout = 1; yin = 1; end
            P_T4:  begin
                grc = 1; rout = 1; zin = 1;
                s_add = (op == 5'd0);
                s_sub = (op == 5'd1);
                s_and = (op == 5'd2);
                s_or  = (op == 5'd3);
            end
            P_T5:  begin zlowout = 1; gra = 1; rin = 1; end
            default: ;
        endcase
        return {pcout, zlowout, mdrout, marin, zin, pcin, mdrin, irin, yin,
                incpc, read, s_add, s_sub, s_and, s_or, gra, grb, grc, rin, rout, run};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_cycle(input int ph, input logic [4:0] op, input logic [31:0] ir,
                             input logic mr, input logic stp, input logic rs);
        @(posedge clk);
        #1;
        bus.IR        = ir;
        bus.Mem_ready = mr;
        bus.Stop      = stp;
        rst           = rs;
        exp_q.push_back({strobes_for(ph, op), m_count});
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction from T0 to its retiring cycle. waits = number of T1W
    // cycles; stop_at / reset_at = phase index carrying a Stop / Reset pulse.
    task automatic do_instr(input logic [31:0] ir, input int waits,
                            input int stop_at, input int reset_at);
        int ph_list[$];
        logic [4:0] op;
        logic mr;
        logic [31:0] cur_ir;
        int ph;
        op = ir[31:27];
        ph_list.push_back(P_T0);
        ph_list.push_back(P_T1);
        for (int w = 0; w < waits; w++) ph_list.push_back(P_T1W);
        ph_list.push_back(P_T2);
        ph_list.push_back(P_T3);
        if (op <= 5'd3) begin
            ph_list.push_back(P_T4);
            ph_list.push_back(P_T5);
        end
        for (int i = 0; i < ph_list.size(); i++) begin
            ph = ph_list[i];
            mr = rbit();
            if (ph == P_T1)  mr = (waits == 0);
            if (ph == P_T1W) mr = (i == 1 + waits);
            cur_ir = ((ph == P_T3) || (ph == P_T4)) ? ir : $urandom;
            run_cycle(ph, op, cur_ir, mr, (i == stop_at), (i == reset_at));
            if (i == reset_at) begin
                m_count  = '0;
                m_stop   = 0;
                m_halted = 0;
                run_cycle(P_RST, 5'd0, $urandom, rbit(), rbit(), 1'b0);
                return;
            end
            if (i == stop_at) m_stop = 1;
            if (i == ph_list.size() - 1) begin
                m_count = m_count + 1'b1;
                if ((op == 5'h1F) || m_stop) m_halted = 1;
            end
        end
    endtask

    task automatic do_halt(input int n);
        for (int i = 0; i < n; i++)
            run_cycle(P_HALT, 5'd0, $urandom, rbit(), rbit(), 1'b0);
    endtask

    task automatic do_reset();
        run_cycle(P_HALT, 5'd0, $urandom, rbit(), rbit(), 1'b1);
        m_count  = '0;
        m_stop   = 0;
        m_halted = 0;
        run_cycle(P_RST, 5'd0, $urandom, rbit(), rbit(), 1'b0);
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op);
        return {op, 27'($urandom)};
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] mon_act;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.Zin,
                       bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.IncPC,
                       bus.Read, bus.ADD, bus.SUB, bus.AND, bus.OR, bus.Gra,
                       bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.Run,
                       bus.Instr_count};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_err++;
                $display("FAIL cycle_check t=%0t strobes=%b count=%0d, required strobes=%b count=%0d",
                         $time, mon_act[EW-1:CNT_W], mon_act[CNT_W-1:0],
                         mon_exp[EW-1:CNT_W], mon_exp[CNT_W-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r, waits, len, stop_at, reset_at;
        logic [4:0] op;
        bus.IR        = '0;
        bus.Mem_ready = 1'b0;
        bus.Stop      = 1'b0;
        m_count       = '0;
        m_stop        = 0;
        m_halted      = 0;

        // First cycle after the power-on reset edge: RST, all zero.
        run_cycle(P_RST, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        // AND R2,R5,R6 with and without memory wait.
        do_instr(32'h112B0000, 0, -1, -1);
        do_instr(32'h112B0000, 3, -1, -1);
        // ADD, SUB, OR.
        do_instr(mk_ir(5'b00000), 0, -1, -1);
        do_instr(mk_ir(5'b00001), 1, -1, -1);
        do_instr(mk_ir(5'b00011), 0, -1, -1);
        // HALT opcode, hold, then reset.
        do_instr(32'hF8000000, 0, -1, -1);
        do_halt(20);
        do_reset();
        // Stop pulse in T1 of an ALU instruction.
        do_instr(32'h112B0000, 0, 1, -1);
        do_halt(5);
        do_reset();
        // Reset during T4, then a NOP.
        do_instr(32'h112B0000, 0, -1, 4);
        do_instr(mk_ir(5'b00101), 0, -1, -1);
        // Stop arriving exactly in the retiring cycle of a NOP.
        do_instr(mk_ir(5'b00111), 0, 3, -1);
        do_halt(3);
        do_reset();
        // Enough NOPs to wrap the counter.
        for (int k = 0; k < 70; k++) do_instr(mk_ir(5'($urandom_range(4, 30))), 0, -1, -1);

        // Randomized instruction stream.
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      op = 5'($urandom_range(0, 3));
            else if (r < 92) op = 5'($urandom_range(4, 30));
            else             op = 5'h1F;
            waits    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            len      = ((op <= 5'd3) ? 6 : 4) + waits;
            stop_at  = ($urandom_range(0, 99) < 6) ? $urandom_range(0, len - 1) : -1;
            reset_at = ($urandom_range(0, 99) < 5) ? $urandom_range(0, len - 1) : -1;
            do_instr(mk_ir(op), waits, stop_at, reset_at);
            if (m_halted) begin
                do_halt($urandom_range(1, 6));
                do_reset();
            end
        end

        // Let the monitor drain the last expectation.
        repeat (2) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain left=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
